// File: rtl/booth_uart_pkg.sv
// Shared constants for the Booth multiplier UART link: ASCII codes, controller
// states and the bit-to-digit helper.
package booth_uart_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ERR  = 8'h45;

    typedef enum logic [2:0] {
        ST_RX_A    = 3'd0,
        ST_RX_B    = 3'd1,
        ST_CALC    = 3'd2,
        ST_TX      = 3'd3,
        ST_TX_TERM = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    function automatic logic [7:0] bit_to_ascii(input logic b);
        return {7'b0011000, b};
    endfunction

endpackage

// File: rtl/booth_seq.sv
// Sequential radix-2 Booth multiplier: one iteration per cycle after start,
// done pulses for one cycle once the product register is final.
module booth_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

    // One extra accumulator bit keeps -2^(WIDTH-1) as multiplicand exact.
    logic [WIDTH:0]   acc_q, acc_d, sum_s, mcand_ext_s;
    logic [WIDTH-1:0] mult_q, mult_d, mcand_q, mcand_d;
    logic             qm1_q, qm1_d, run_q, run_d, done_q, done_d;
    logic [IW-1:0]    iter_q, iter_d;

    // Booth recode, add/subtract and arithmetic shift of {A,Q,Q-1}.
    always_comb begin
        mcand_ext_s = {mcand_q[WIDTH-1], mcand_q};
        case ({mult_q[0], qm1_q})
            2'b01:   sum_s = acc_q + mcand_ext_s;
            2'b10:   sum_s = acc_q - mcand_ext_s;
            default: sum_s = acc_q;
        endcase
        acc_d   = acc_q;
        mult_d  = mult_q;
        qm1_d   = qm1_q;
        mcand_d = mcand_q;
        iter_d  = iter_q;
        run_d   = run_q;
        done_d  = 1'b0;
        if (start) begin
            acc_d   = {(WIDTH+1){1'b0}};
            mult_d  = q;
            qm1_d   = 1'b0;
            mcand_d = m;
            iter_d  = {IW{1'b0}};
            run_d   = 1'b1;
        end else if (run_q) begin
            acc_d  = {sum_s[WIDTH], sum_s[WIDTH:1]};
            mult_d = {sum_s[0], mult_q[WIDTH-1:1]};
            qm1_d  = mult_q[0];
            if (iter_q == LAST_ITER) begin
                iter_d = {IW{1'b0}};
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                iter_d = iter_q + IW'(1);
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Datapath and sequencing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= {(WIDTH+1){1'b0}};
            mult_q  <= {WIDTH{1'b0}};
            qm1_q   <= 1'b0;
            mcand_q <= {WIDTH{1'b0}};
            iter_q  <= {IW{1'b0}};
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mult_q  <= mult_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            iter_q  <= iter_d;
            run_q   <= run_d;
            done_q  <= done_d;
        end
    end

    assign done    = done_q;
    assign product = {acc_q[WIDTH-1:0], mult_q};

endmodule

// File: rtl/booth_uart_link.sv
// UART byte bridge: parses two ASCII-binary signed operands, multiplies them with
// booth_seq and streams the product back as ASCII digits with optional CR LF.
module booth_uart_link
    import booth_uart_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit TERM_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overrun
);

    localparam int CW = $clog2(2*WIDTH + 1);
    localparam logic [CW-1:0] LAST_OPND = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_TX   = CW'(2*WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d, overrun_q, overrun_d, busy_q, busy_d;
    logic             hs_s, is_digit_s, is_eol_s, busy_s, start_s, done_s;
    logic [2*WIDTH-1:0] product_s, tx_shift_s;

    booth_seq #(.WIDTH(WIDTH)) u_booth (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s),
        .m       (opa_q),
        .q       (opb_q),
        .done    (done_s),
        .product (product_s)
    );

    // Controller: parser, multiplier kick-off, TX sequencing and overrun detect.
    always_comb begin
        hs_s       = tx_valid_q && tx_ready;
        is_digit_s = (rx_data == ASCII_ZERO) || (rx_data == ASCII_ONE);
        is_eol_s   = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
        busy_s     = (state_q != ST_RX_A) && (state_q != ST_RX_B);
        // cnt stays 0 only during the first CALC cycle, giving a single start pulse.
        start_s    = (state_q == ST_CALC) && (cnt_q == {CW{1'b0}});
        tx_shift_s = product_s << (cnt_q + CW'(1));
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        overrun_d  = rx_valid && busy_s;
        case (state_q)
            ST_RX_A, ST_RX_B: begin
                if (rx_valid) begin
                    if (is_digit_s) begin
                        if (state_q == ST_RX_A) begin
                            opa_d = {opa_q[WIDTH-2:0], rx_data[0]};
                        end else begin
                            opb_d = {opb_q[WIDTH-2:0], rx_data[0]};
                        end
                        if (cnt_q == LAST_OPND) begin
                            cnt_d   = {CW{1'b0}};
                            state_d = (state_q == ST_RX_A) ? ST_RX_B : ST_CALC;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (is_eol_s) begin
                        cnt_d = cnt_q;
                    end else begin
                        state_d    = ST_ERR;
                        cnt_d      = {CW{1'b0}};
                        opa_d      = {WIDTH{1'b0}};
                        opb_d      = {WIDTH{1'b0}};
                        tx_data_d  = ASCII_ERR;
                        tx_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_CALC: begin
                if (done_s) begin
                    state_d    = ST_TX;
                    cnt_d      = {CW{1'b0}};
                    tx_data_d  = bit_to_ascii(product_s[2*WIDTH-1]);
                    tx_valid_d = 1'b1;
                end else begin
                    cnt_d = CW'(1);
                end
            end
            ST_TX: begin
                if (hs_s) begin
                    if (cnt_q == LAST_TX) begin
                        cnt_d = {CW{1'b0}};
                        if (TERM_EN) begin
                            state_d   = ST_TX_TERM;
                            tx_data_d = ASCII_CR;
                        end else begin
                            state_d    = ST_RX_A;
                            tx_data_d  = 8'h00;
                            tx_valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d     = cnt_q + CW'(1);
                        tx_data_d = bit_to_ascii(tx_shift_s[2*WIDTH-1]);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_TX_TERM: begin
                if (hs_s) begin
                    if (cnt_q == {CW{1'b0}}) begin
                        cnt_d     = CW'(1);
                        tx_data_d = ASCII_LF;
                    end else begin
                        state_d    = ST_RX_A;
                        cnt_d      = {CW{1'b0}};
                        tx_data_d  = 8'h00;
                        tx_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ERR: begin
                if (hs_s) begin
                    state_d    = ST_RX_A;
                    cnt_d      = {CW{1'b0}};
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d    = ST_RX_A;
                cnt_d      = {CW{1'b0}};
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_RX_A) && (state_d != ST_RX_B);
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RX_A;
            cnt_q      <= {CW{1'b0}};
            opa_q      <= {WIDTH{1'b0}};
            opb_q      <= {WIDTH{1'b0}};
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_booth_uart_link.sv
// Scoreboard bench: a W=4 link with CR/LF for directed cases and a W=8 link
// without terminator for a randomized regression against signed multiplication.
module tb_booth_uart_link;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data4, rx_data8, tx_data4, tx_data8;
    logic       rx_valid4, rx_valid8, tx_valid4, tx_valid8;
    logic       tx_ready4, tx_ready8, busy4, busy8, overrun4, overrun8;
    logic       rand_ready8 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int ov4 = 0, ov8 = 0, tx8_count = 0;
    logic [7:0] q4[$];
    logic [7:0] q8[$];
    logic       stall4 = 1'b0, stall8 = 1'b0;
    logic [7:0] held4, held8;

    always #10 clk = ~clk;

    booth_uart_link #(.WIDTH(4), .TERM_EN(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data4), .rx_valid(rx_valid4),
        .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
        .busy(busy4), .overrun(overrun4)
    );

    booth_uart_link #(.WIDTH(8), .TERM_EN(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data8), .rx_valid(rx_valid8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .busy(busy8), .overrun(overrun8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int sext(input logic [15:0] v, input int w);
        int x;
        x = int'(v) & ((1 << w) - 1);
        if (x >= (1 << (w - 1))) x = x - (1 << w);
        return x;
    endfunction

    // Reference: exact signed product rendered as 2w ASCII digits, MSB first.
    task automatic push_expected(input bit sel, input int w, input logic [15:0] a,
                                 input logic [15:0] b, input bit term);
        int p;
        logic [7:0] ch;
        p = sext(a, w) * sext(b, w);
        for (int i = 2*w - 1; i >= 0; i--) begin
            ch = (((p >> i) & 1) != 0) ? 8'h31 : 8'h30;
            if (sel) q8.push_back(ch); else q4.push_back(ch);
        end
        if (term) begin
            if (sel) begin q8.push_back(8'h0D); q8.push_back(8'h0A); end
            else     begin q4.push_back(8'h0D); q4.push_back(8'h0A); end
        end
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        if (sel) begin rx_data8 = b; rx_valid8 = 1'b1; end
        else     begin rx_data4 = b; rx_valid4 = 1'b1; end
        @(posedge clk); #1;
        rx_valid4 = 1'b0;
        rx_valid8 = 1'b0;
    endtask

    task automatic send_operand(input bit sel, input int w, input logic [15:0] v);
        for (int i = w - 1; i >= 0; i--) send_byte(sel, v[i] ? 8'h31 : 8'h30);
    endtask

    task automatic wait_idle(input bit sel);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (((sel ? q8.size() : q4.size()) == 0) && !(sel ? busy8 : busy4)) break;
            @(posedge clk); #1;
        end
        if (k == 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle%0d: timeout, %0d bytes outstanding", sel,
                     sel ? q8.size() : q4.size());
        end
    endtask

    task automatic run_op(input bit sel, input int w, input logic [15:0] a,
                          input logic [15:0] b, input bit term);
        push_expected(sel, w, a, b, term);
        send_operand(sel, w, a);
        send_operand(sel, w, b);
        wait_idle(sel);
    endtask

    // Scoreboard monitor, W=4 link: pop on handshake, check hold during stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall4 = 1'b0;
        end else begin
            if (overrun4) ov4++;
            if (stall4) begin
                check("tx4_hold_valid", {31'd0, tx_valid4}, 32'd1);
                check("tx4_hold_data", {24'd0, tx_data4}, {24'd0, held4});
            end
            if (tx_valid4 && tx_ready4) begin
                if (q4.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx4_extra: got %0h, expected no byte", tx_data4);
                end else begin
                    check("tx4_byte", {24'd0, tx_data4}, {24'd0, q4.pop_front()});
                end
            end
            stall4 = tx_valid4 && !tx_ready4;
            held4  = tx_data4;
        end
    end

    // Scoreboard monitor, W=8 link.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall8 = 1'b0;
        end else begin
            if (overrun8) ov8++;
            if (stall8) begin
                check("tx8_hold_valid", {31'd0, tx_valid8}, 32'd1);
                check("tx8_hold_data", {24'd0, tx_data8}, {24'd0, held8});
            end
            if (tx_valid8 && tx_ready8) begin
                tx8_count++;
                if (q8.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx8_extra: got %0h, expected no byte", tx_data8);
                end else begin
                    check("tx8_byte", {24'd0, tx_data8}, {24'd0, q8.pop_front()});
                end
            end
            stall8 = tx_valid8 && !tx_ready8;
            held8  = tx_data8;
        end
    end

    // Random receiver backpressure for the W=8 link.
    initial begin
        tx_ready8 = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready8 = rand_ready8 ? ($urandom_range(0, 7) != 0) : 1'b1;
        end
    end

    initial begin
        int lat, k, ov_before, n_ops8;
        rst_n = 1'b0;
        rx_data4 = 8'h00; rx_data8 = 8'h00;
        rx_valid4 = 1'b0; rx_valid8 = 1'b0;
        tx_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid4", {31'd0, tx_valid4}, 32'd0);
        check("rst_tx_data4", {24'd0, tx_data4}, 32'd0);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_overrun4", {31'd0, overrun4}, 32'd0);
        check("rst_tx_valid8", {31'd0, tx_valid8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3 x -7 with first-digit latency measured from the last accepted digit.
        push_expected(1'b0, 4, 16'h3, 16'h9, 1'b1);
        send_operand(1'b0, 4, 16'h3);
        send_operand(1'b0, 4, 16'h9);
        for (lat = 1; lat <= 20; lat++) begin
            @(posedge clk); #1;
            if (tx_valid4) break;
        end
        check("latency4", lat, 6);
        wait_idle(1'b0);

        run_op(1'b0, 4, 16'h8, 16'h8, 1'b1);
        run_op(1'b0, 4, 16'h7, 16'h7, 1'b1);

        // Illegal byte, then recovery.
        q4.push_back(8'h45);
        send_byte(1'b0, 8'h30);
        send_byte(1'b0, 8'h31);
        send_byte(1'b0, 8'h32);
        wait_idle(1'b0);
        run_op(1'b0, 4, 16'h1, 16'h1, 1'b1);

        // CR/LF between digits are ignored.
        push_expected(1'b0, 4, 16'h3, 16'hF, 1'b1);
        send_byte(1'b0, 8'h30); send_byte(1'b0, 8'h30); send_byte(1'b0, 8'h0D);
        send_byte(1'b0, 8'h31); send_byte(1'b0, 8'h31); send_byte(1'b0, 8'h0A);
        send_operand(1'b0, 4, 16'hF);
        wait_idle(1'b0);

        // Ten stalled cycles in the middle of the product.
        push_expected(1'b0, 4, 16'h5, 16'hD, 1'b1);
        send_operand(1'b0, 4, 16'h5);
        send_operand(1'b0, 4, 16'hD);
        repeat (9) @(posedge clk);
        #1 tx_ready4 = 1'b0;
        repeat (10) @(posedge clk);
        #1 tx_ready4 = 1'b1;
        wait_idle(1'b0);

        // Byte arriving during CALC is dropped with a single overrun pulse.
        ov_before = ov4;
        push_expected(1'b0, 4, 16'h6, 16'hB, 1'b1);
        send_operand(1'b0, 4, 16'h6);
        send_operand(1'b0, 4, 16'hB);
        send_byte(1'b0, 8'h31);
        wait_idle(1'b0);
        check("overrun_calc", ov4 - ov_before, 1);
        run_op(1'b0, 4, 16'h2, 16'hE, 1'b1);

        // Reset while transmitting.
        push_expected(1'b0, 4, 16'h4, 16'h5, 1'b1);
        send_operand(1'b0, 4, 16'h4);
        send_operand(1'b0, 4, 16'h5);
        for (k = 0; k < 50; k++) begin
            if (tx_valid4) break;
            @(posedge clk); #1;
        end
        check("tx4_started", {31'd0, tx_valid4}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midtx_rst_valid", {31'd0, tx_valid4}, 32'd0);
        check("midtx_rst_data", {24'd0, tx_data4}, 32'd0);
        check("midtx_rst_busy", {31'd0, busy4}, 32'd0);
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 4, 16'hC, 16'h3, 1'b1);

        for (int i = 0; i < 20; i++)
            run_op(1'b0, 4, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), 1'b1);

        // W=8 regression, no terminator expected.
        rand_ready8 = 1'b1;
        tx8_count = 0;
        run_op(1'b1, 8, 16'h80, 16'h80, 1'b0);
        run_op(1'b1, 8, 16'h7F, 16'h80, 1'b0);
        n_ops8 = 2;
        for (int i = 0; i < 1000; i++) begin
            run_op(1'b1, 8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0);
            n_ops8++;
        end
        rand_ready8 = 1'b0;
        check("tx8_byte_count", tx8_count, 16 * n_ops8);
        check("q4_drained", q4.size(), 0);
        check("q8_drained", q8.size(), 0);
        check("no_overrun8", ov8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
